// File: rtl/note_play_ctrl.sv
// rtl/note_play_ctrl.sv - debounced priority note keys plus ROM auto-play melody sequencer
// Optional macro REST_GAP_EN inserts a BEAT_CYCLES/8 silent gap between melody notes.
module note_play_ctrl #(
  parameter logic [19:0]  DEB_CYCLES  = 20'd500000,
  parameter logic [23:0]  BEAT_CYCLES = 24'd6000000,
  parameter int           SONG_LEN    = 32,
  // 4-bit codes, entry i at bits [4i+3:4i]
  parameter logic [255:0] SONG_ROM    = 256'hF2334455_02334455_01223344_05665511
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [13:0] Key,
  input  logic        play_btn,
  output logic [13:0] key_out,
  output logic        busy,
  output logic [5:0]  note_idx
);

  localparam logic [5:0] LAST_IDX = 6'(SONG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    PLAY   = 2'd2
`ifdef REST_GAP_EN
    , GAP  = 2'd3
`endif
  } state_t;

  state_t      state;
  logic [13:0] key_s;
  logic [13:0] key_deb;
  logic [19:0] deb_cnt;
  logic [23:0] beat_cnt;
  logic        play_prev;

`ifdef REST_GAP_EN
  localparam logic [23:0] GAP_LEN = (BEAT_CYCLES < 24'd8) ? 24'd1 : (BEAT_CYCLES >> 3);
  logic [23:0] gap_cnt;
`endif

  function automatic logic [3:0] rom_code(input logic [5:0] a);
    return SONG_ROM[{a, 2'b00} +: 4];
  endfunction

  function automatic logic [13:0] note_bits(input logic [3:0] c);
    if (c == 4'd0 || c == 4'hF) return 14'd0;
    return 14'd1 << (c - 4'd1);
  endfunction

  function automatic logic [13:0] lowest_bit(input logic [13:0] k);
    return k & (~k + 14'd1);
  endfunction

  // The counter saturates at DEB_CYCLES-1 and keeps reloading key_deb while key_s holds.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      key_s   <= '0;
      key_deb <= '0;
      deb_cnt <= '0;
    end else begin
      key_s <= Key;
      if (Key != key_s)
        deb_cnt <= '0;
      else if (deb_cnt == DEB_CYCLES - 20'd1)
        key_deb <= key_s;
      else
        deb_cnt <= deb_cnt + 20'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      key_out   <= '0;
      busy      <= 1'b0;
      note_idx  <= '0;
      beat_cnt  <= '0;
      play_prev <= 1'b0;
`ifdef REST_GAP_EN
      gap_cnt   <= '0;
`endif
    end else begin
      play_prev <= play_btn;
      case (state)
        IDLE: begin
          busy     <= 1'b0;
          note_idx <= '0;
          if (key_deb != '0) begin
            state   <= MANUAL;
            key_out <= lowest_bit(key_deb);
          end else if (play_btn && !play_prev) begin
            state    <= PLAY;
            busy     <= 1'b1;
            beat_cnt <= '0;
            key_out  <= note_bits(rom_code(6'd0));
          end else begin
            key_out <= '0;
          end
        end

        MANUAL: begin
          key_out <= lowest_bit(key_deb);
          if (key_deb == '0) state <= IDLE;
        end

        PLAY: begin
          // A held key always beats the melody, even on a terminal beat.
          if (key_deb != '0) begin
            state    <= MANUAL;
            busy     <= 1'b0;
            note_idx <= '0;
            key_out  <= lowest_bit(key_deb);
          end else if (rom_code(note_idx) == 4'hF) begin
            state    <= IDLE;
            busy     <= 1'b0;
            note_idx <= '0;
            key_out  <= '0;
          end else if (beat_cnt == BEAT_CYCLES - 24'd1) begin
            beat_cnt <= '0;
            if (note_idx == LAST_IDX) begin
              state    <= IDLE;
              busy     <= 1'b0;
              note_idx <= '0;
              key_out  <= '0;
            end else begin
              note_idx <= note_idx + 6'd1;
`ifdef REST_GAP_EN
              state    <= GAP;
              gap_cnt  <= '0;
              key_out  <= '0;
`else
              key_out  <= note_bits(rom_code(note_idx + 6'd1));
`endif
            end
          end else begin
            beat_cnt <= beat_cnt + 24'd1;
          end
        end

`ifdef REST_GAP_EN
        GAP: begin
          if (key_deb != '0) begin
            state    <= MANUAL;
            busy     <= 1'b0;
            note_idx <= '0;
            key_out  <= lowest_bit(key_deb);
          end else if (gap_cnt == GAP_LEN - 24'd1) begin
            state    <= PLAY;
            beat_cnt <= '0;
            key_out  <= note_bits(rom_code(note_idx));
          end else begin
            gap_cnt <= gap_cnt + 24'd1;
          end
        end
`endif

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          note_idx <= '0;
          key_out  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_play_ctrl.sv
// tb/tb_note_play_ctrl.sv - randomized bench for note_play_ctrl against a timeline-based model
module tb_note_play_ctrl;

  localparam logic [19:0]  DEB   = 20'd4;
  localparam logic [23:0]  BEAT  = 24'd8;
  localparam int           SLEN  = 4;
  localparam logic [255:0] ROM   = 256'hF081;
  localparam int           DEB_I = 4;
  localparam int           BEAT_I = 8;
`ifdef REST_GAP_EN
  localparam int           GAPC  = 1;
`else
  localparam int           GAPC  = 0;
`endif

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] Key = 14'h3FFF;
  logic        play_btn = 1'b0;
  logic [13:0] key_out;
  logic        busy;
  logic [5:0]  note_idx;

  int total = 0;
  int bad = 0;

  note_play_ctrl #(
    .DEB_CYCLES(DEB), .BEAT_CYCLES(BEAT), .SONG_LEN(SLEN), .SONG_ROM(ROM)
  ) dut (
    .clk_in(clk_in), .rst(rst), .Key(Key), .play_btn(play_btn),
    .key_out(key_out), .busy(busy), .note_idx(note_idx)
  );

  always #5 clk_in = ~clk_in;

  int          rom_m [SLEN] = '{1, 8, 0, 15};
  logic [13:0] hist [$];
  logic [13:0] m_deb = '0;
  logic [13:0] m_key_out = '0;
  logic        m_busy = 1'b0;
  logic [5:0]  m_idx = '0;
  int          mode = 0;
  int          edge_n = 0;
  int          play_start = 0;
  logic        prev_btn = 1'b0;
  bit          model_valid = 1'b0;

  function automatic logic [13:0] note_bit(int code);
    logic [13:0] one;
    one = 14'd1;
    if (code < 1 || code > 14) return 14'd0;
    return one << (code - 1);
  endfunction

  function automatic logic [13:0] lowest(logic [13:0] k);
    logic [13:0] one;
    one = 14'd1;
    for (int i = 0; i < 14; i++) if (k[i]) return one << i;
    return 14'd0;
  endfunction

  // Offset from play start at which the sequencer is back in idle.
  function automatic int end_off();
    for (int m = 0; m < SLEN; m++)
      if (rom_m[m] == 15) return m * (BEAT_I + GAPC) + 1;
    return (SLEN - 1) * (BEAT_I + GAPC) + BEAT_I;
  endfunction

  task automatic set_play(int off);
    int n, r;
    n = off / (BEAT_I + GAPC);
    r = off % (BEAT_I + GAPC);
    m_busy = 1'b1;
    if (r < BEAT_I) begin
      m_idx = 6'(n);
      m_key_out = note_bit(rom_m[n]);
    end else begin
      m_idx = 6'(n + 1);
      m_key_out = '0;
    end
  endtask

  task automatic model_step();
    logic [13:0] deb_before, k;
    logic        rise;
    bit          all_eq;
    int          off;
    k = Key;
    edge_n++;
    if (rst) begin
      hist.delete();
      hist.push_back(14'd0);
      m_deb = '0; m_key_out = '0; m_busy = 1'b0; m_idx = '0;
      mode = 0; prev_btn = 1'b0; model_valid = 1'b1;
      return;
    end
    deb_before = m_deb;
    rise = play_btn && !prev_btn;
    prev_btn = play_btn;
    hist.push_back(k);
    if (hist.size() > DEB_I + 1) void'(hist.pop_front());
    if (hist.size() == DEB_I + 1) begin
      all_eq = 1'b1;
      foreach (hist[i]) if (hist[i] != k) all_eq = 1'b0;
      if (all_eq) m_deb = k;
    end
    if (mode == 2 && deb_before != '0) begin
      mode = 1; m_key_out = lowest(deb_before); m_busy = 1'b0; m_idx = '0;
    end else if (mode == 2) begin
      off = edge_n - play_start;
      if (off >= end_off()) begin
        mode = 0; m_key_out = '0; m_busy = 1'b0; m_idx = '0;
      end else begin
        set_play(off);
      end
    end else if (deb_before != '0) begin
      mode = 1; m_key_out = lowest(deb_before); m_busy = 1'b0; m_idx = '0;
    end else if (mode == 0 && rise) begin
      mode = 2; play_start = edge_n; set_play(0);
    end else begin
      mode = 0; m_key_out = '0; m_busy = 1'b0; m_idx = '0;
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    model_step();
  end

  task automatic chk(string nm, logic [13:0] act, logic [13:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic lit(string nm, logic [13:0] dut_v, logic [13:0] mod_v, logic [13:0] exp_v);
    chk({nm, "_dut"}, dut_v, exp_v);
    chk({nm, "_model"}, mod_v, exp_v);
  endtask

  always @(negedge clk_in) begin
    if (model_valid) begin
      chk("key_out", key_out, m_key_out);
      chk("busy", 14'(busy), 14'(m_busy));
      chk("note_idx", 14'(note_idx), 14'(m_idx));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    int hold, r, j, plen;
    logic [13:0] ek;
    logic [5:0]  ei;
    logic        eb;

    repeat (2) begin
      @(negedge clk_in);
      lit("rst_key_out", key_out, m_key_out, 14'h0000);
      lit("rst_busy", 14'(busy), 14'(m_busy), 14'h0000);
      lit("rst_idx", 14'(note_idx), 14'(m_idx), 14'h0000);
    end

    rst = 1'b0; Key = 14'h0004;
    cyc(5);
    lit("deb_early", key_out, m_key_out, 14'h0000);
    cyc(1);
    lit("deb_accept", key_out, m_key_out, 14'h0004);

    Key = 14'h0001;
    for (int i = 0; i < 3; i++) begin cyc(1); lit("glitch", key_out, m_key_out, 14'h0004); end
    Key = 14'h0004;
    for (int i = 0; i < 8; i++) begin cyc(1); lit("glitch_after", key_out, m_key_out, 14'h0004); end

    Key = 14'h2081;
    cyc(5);
    lit("prio_early", key_out, m_key_out, 14'h0004);
    cyc(1);
    lit("prio", key_out, m_key_out, 14'h0001);
    Key = 14'h0000;
    cyc(5);
    lit("release_early", key_out, m_key_out, 14'h0001);
    cyc(1);
    lit("release", key_out, m_key_out, 14'h0000);
    cyc(3);

    play_btn = 1'b1;
    cyc(1);
    play_btn = 1'b0;
`ifdef REST_GAP_EN
    plen = 29;
`else
    plen = 26;
`endif
    for (j = 0; j < plen; j++) begin
`ifdef REST_GAP_EN
      if (j < 8)       begin ek = 14'h0001; ei = 6'd0; end
      else if (j == 8) begin ek = 14'h0000; ei = 6'd1; end
      else if (j < 17) begin ek = 14'h0080; ei = 6'd1; end
      else if (j < 26) begin ek = 14'h0000; ei = 6'd2; end
      else if (j < 28) begin ek = 14'h0000; ei = 6'd3; end
      else             begin ek = 14'h0000; ei = 6'd0; end
      eb = (j < 28);
`else
      if (j < 8)       begin ek = 14'h0001; ei = 6'd0; end
      else if (j < 16) begin ek = 14'h0080; ei = 6'd1; end
      else if (j < 24) begin ek = 14'h0000; ei = 6'd2; end
      else if (j == 24) begin ek = 14'h0000; ei = 6'd3; end
      else             begin ek = 14'h0000; ei = 6'd0; end
      eb = (j < 25);
`endif
      lit("play_key", key_out, m_key_out, ek);
      lit("play_busy", 14'(busy), 14'(m_busy), 14'(eb));
      lit("play_idx", 14'(note_idx), 14'(m_idx), 14'(ei));
      cyc(1);
    end

    cyc(2);
    play_btn = 1'b1;
    cyc(1);
    play_btn = 1'b0;
    cyc(3);
    Key = 14'h0010;
    cyc(5);
    lit("abort_early_busy", 14'(busy), 14'(m_busy), 14'h0001);
    cyc(1);
    lit("abort_busy", 14'(busy), 14'(m_busy), 14'h0000);
    lit("abort_idx", 14'(note_idx), 14'(m_idx), 14'h0000);
    lit("abort_key", key_out, m_key_out, 14'h0010);
    Key = 14'h0000;
    cyc(10);

    repeat (220) begin
      r = $urandom_range(0, 99);
      rst = (r < 4);
      if (r < 50)      Key = 14'h0000;
      else if (r < 82) Key = note_bit($urandom_range(1, 14));
      else             Key = 14'($urandom);
      hold = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) begin
        play_btn = 1'b1;
        cyc(1);
        if (hold == 0) play_btn = 1'b0;
      end
      cyc($urandom_range(1, 30));
    end
    rst = 1'b0; Key = 14'h0000; play_btn = 1'b0;
    cyc(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
